// File: rtl/mole_presenter.sv
// -----------------------------------------------------------------------------
// mole_presenter
//   Mole side of the whack-a-mole game. It picks a pseudo-random mole and lights
//   exactly one LED for a bounded number of ticks. It then reports each correct
//   or wrong press, and each expired mole, to the score counter as a one-cycle
//   hit/miss pulse.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   enable     game running (level); low returns the block to IDLE
//   tick       one-cycle pacing strobe, synchronous to clk
//   button_db  debounced button levels, 1 = pressed
//   led_out    one-hot lit mole, or all zero
//   mole_idx   index of the current or last mole
//   hit        one-cycle pulse: correct press
//   miss       one-cycle pulse: wrong press or mole expired
// -----------------------------------------------------------------------------
module mole_presenter #(
    parameter int         NUM_MOLES  = 5,
    parameter int         LIFE_TICKS = 3,
    parameter int         GAP_TICKS  = 1,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 tick,
    input  logic [NUM_MOLES-1:0] button_db,
    output logic [NUM_MOLES-1:0] led_out,
    output logic [2:0]           mole_idx,
    output logic                 hit,
    output logic                 miss
);

    localparam int         GAP_W  = $clog2(GAP_TICKS + 1);
    localparam int         LIFE_W = $clog2(LIFE_TICKS + 1);
    localparam logic [3:0] NM     = 4'(NUM_MOLES);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        UP
    } state_t;

    state_t               state;
    logic [7:0]           lfsr;
    logic [7:0]           lfsr_next;
    logic [NUM_MOLES-1:0] btn_prev;
    logic [NUM_MOLES-1:0] rise;
    logic [GAP_W-1:0]     gap_cnt;
    logic [LIFE_W-1:0]    life_cnt;
    logic [3:0]           c_raw;
    logic [3:0]           c_mod;
    logic [3:0]           cand;
    logic [NUM_MOLES-1:0] cand_onehot;
    logic                 correct_press;
    logic                 wrong_press;

    // NOTE: every signal written here gets a default value first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        // Galois LFSR, polynomial x^8+x^6+x^5+x^4+1 (right-shifting, mask 0xB8).
        lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

        rise = button_db & ~btn_prev;

        // In UP, led_out is the one-hot mask of mole_idx, so it separates the
        // correct button from all the others without indexing by mole_idx.
        correct_press = |(rise & led_out);
        wrong_press   = |(rise & ~led_out);

        // Fold the low LFSR bits into range. For NUM_MOLES >= 4 this is the
        // same as a single conditional subtract; modulo also covers 2 and 3.
        c_raw = {1'b0, lfsr[2:0]};
        c_mod = c_raw % NM;

        // Never show the same mole twice in a row.
        cand = c_mod;
        if (c_mod == {1'b0, mole_idx}) begin
            cand = (c_mod == NM - 4'd1) ? 4'd0 : c_mod + 4'd1;
        end

        cand_onehot = NUM_MOLES'(1) << cand;
    end

    // NOTE: sequential state is assigned only with non-blocking (<=) updates,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            led_out  <= '0;
            mole_idx <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            lfsr     <= SEED;
            // All ones: a button held through reset never counts as a press.
            btn_prev <= '1;
            gap_cnt  <= '0;
            life_cnt <= '0;
        end else begin
            btn_prev <= button_db;
            hit      <= 1'b0;
            miss     <= 1'b0;

            if (enable) begin
                lfsr <= lfsr_next;
            end

            if (!enable) begin
                state    <= IDLE;
                led_out  <= '0;
                gap_cnt  <= '0;
                life_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        led_out <= '0;
                        gap_cnt <= GAP_W'(GAP_TICKS);
                        state   <= GAP;
                    end

                    GAP: begin
                        // Presses are ignored while all LEDs are dark.
                        if (tick) begin
                            if (gap_cnt == GAP_W'(1)) begin
                                mole_idx <= 3'(cand);
                                led_out  <= cand_onehot;
                                life_cnt <= LIFE_W'(LIFE_TICKS);
                                state    <= UP;
                            end else begin
                                gap_cnt <= gap_cnt - GAP_W'(1);
                            end
                        end
                    end

                    UP: begin
                        // Priority: correct press, wrong press, expiry, countdown.
                        if (correct_press) begin
                            hit     <= 1'b1;
                            led_out <= '0;
                            gap_cnt <= GAP_W'(GAP_TICKS);
                            state   <= GAP;
                        end else if (wrong_press) begin
                            miss    <= 1'b1;
                            led_out <= '0;
                            gap_cnt <= GAP_W'(GAP_TICKS);
                            state   <= GAP;
                        end else if (tick) begin
                            if (life_cnt == LIFE_W'(1)) begin
                                miss    <= 1'b1;
                                led_out <= '0;
                                gap_cnt <= GAP_W'(GAP_TICKS);
                                state   <= GAP;
                            end else begin
                                life_cnt <= life_cnt - LIFE_W'(1);
                            end
                        end
                    end

                    default: begin
                        led_out <= '0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mole_presenter.md
Name: mole_presenter

Overview:
- Drives the mole side of the whack-a-mole game and is the counterpart to the hit-checking logic.
- Picks a pseudo-random mole and lights exactly one LED for a bounded lifetime.
- Watches the debounced buttons and emits one-cycle hit/miss pulses for the score counter.
- Sits between the game-begin control, the debouncers and the LED outputs; paced by a slow tick strobe.

Parameters:
- NUM_MOLES, 5, number of LEDs/buttons (2..8).
- LIFE_TICKS, 3, ticks a mole stays lit before expiring (>=1).
- GAP_TICKS, 1, ticks with all LEDs dark between moles (>=1).
- SEED, 8'hA5, LFSR reset value (nonzero).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  game running (level); low forces IDLE.
- tick  in  1  one-clk-cycle pacing strobe, synchronous to clk.
- button_db  in  NUM_MOLES  debounced button levels, 1 = pressed.
- led_out  out  NUM_MOLES  one-hot lit mole, or all zero.
- mole_idx  out  3  index of the current or last mole.
- hit  out  1  one-cycle pulse: correct press.
- miss  out  1  one-cycle pulse: wrong press or mole expired.

Behaviour:
- Reset (async): state=IDLE, led_out=0, mole_idx=0, hit=0, miss=0, lfsr=SEED, btn_prev=all ones (a button held through reset never counts as a press).
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. Advances every clk while enable=1; holds otherwise.
- Candidate index: c=lfsr[2:0]; if c>=NUM_MOLES, c-=NUM_MOLES. If c equals the previous mole_idx, use (c+1) mod NUM_MOLES, so the same mole never appears twice in a row.
- Edge detect: rise = button_db & ~btn_prev. btn_prev <= button_db every cycle in every state.
- hit and miss default to 0 each cycle and are never high together.
- FSM transitions:
  - IDLE: led_out=0. When enable=1 -> GAP, gap_cnt=GAP_TICKS.
  - GAP: on tick, gap_cnt decrements. A tick with gap_cnt==1 -> UP: mole_idx<=candidate, led_out<=one-hot(candidate), life_cnt<=LIFE_TICKS. Presses in GAP are ignored.
  - UP, priority order:
    1. rise[mole_idx] -> hit<=1, led_out<=0, GAP.
    2. Else any other rise bit -> miss<=1, led_out<=0, GAP.
    3. Else tick with life_cnt==1 -> miss<=1, led_out<=0, GAP.
    4. Else tick -> life_cnt decrements.
- Latency: a press edge seen in cycle N gives hit/miss high in cycle N+1 only, with led_out=0 in the same cycle.
- Simultaneous events: correct rise + wrong rise -> hit. Correct rise + expiring tick -> hit. A tick in the same cycle as the UP->GAP transition is not counted toward the gap.
- enable low in any state: next cycle IDLE, led_out=0, no hit/miss pulse, counters cleared. mole_idx holds.
- A held button generates exactly one rise; re-lighting its mole does not count until it is released and pressed again.
- Counters are sized for their parameters and never wrap; the ==1 checks terminate them.

Test Plan:
1. Assert reset mid-UP with LED lit -> led_out=0, hit=miss=0 within the same cycle, state IDLE after release; hold a button through reset -> no hit/miss after release.
2. enable=1, tick every 10 cycles, no presses -> LED lights 1 tick after enable, stays lit exactly 3 ticks, miss pulses once for 1 cycle, LED dark 1 tick, then a new mole whose idx differs from the previous one.
3. While mole k is lit, raise button_db[k] -> hit=1 for exactly the next cycle, led_out=0; holding the button across the next mole of the same index gives no hit.
4. While mole k is lit, raise button_db[(k+1)%5] -> miss one cycle; raise k and another bit in the same cycle -> hit only.
5. Raise button_db[k] in the same cycle as the expiring tick -> hit, not miss; presses during GAP -> no pulse.
6. Run 200 moles with random presses -> led_out always one-hot or zero, mole_idx always <5, no consecutive repeats, hit+miss count equals the number of moles shown; drop enable mid-UP -> LEDs off next cycle with no pulse.
